seg7_scan: RTL and testbench
============================

// Module: seg7_scan
// PURPOSE
//   Time-multiplexed driver for the 4-digit 7-segment display fed by the SPI block.
//   Captures a 16-bit value on a load strobe and shows it as 4 hex digits.
//   Scans one digit per slot and inserts dead time between digits to stop ghosting.
//   Updates the displayed value only at frame boundaries, so a frame never mixes old and new data.
// PARAMETERS
//   CLKFREQ   27000000  input clock frequency, Hz
//   SCANFREQ  4000      digit-slot rate, Hz; DIV = CLKFREQ/SCANFREQ cycles per slot
//   DEADCYC   16        blanked cycles at the start of each slot; DIV >= DEADCYC+2 (elaboration check)
// PORTS
//   clk         in   1   system clock
//   rst         in   1   asynchronous reset, active-low
//   data_in     in   16  value to display; nibble k -> digit k
//   load        in   1   1-cycle strobe; samples data_in and dp_in
//   dp_in       in   4   decimal point per digit, 1 = lit
//   digits      out  4   digit enables, active-low; digits[0] = least-significant digit
//   segments    out  8   active-low; [0]=a .. [6]=g, [7]=dp
//   frame_tick  out  1   1-cycle pulse when the digit-0 slot starts (the shadow register loads here)
// BEHAVIOUR
//   Reset (rst=0, asynchronous): digits=4'hF, segments=8'hFF, frame_tick=0.
//     pending, shadow and dp registers=0; idx=0; cnt=0; state=DEAD.
//   cnt counts 0..DIV-1 and wraps. At the wrap, idx advances 3->0 modulo 4.
//   FSM per slot:
//     DEAD:  cnt < DEADCYC; digits=4'hF, segments=8'hFF. Go to DRIVE when cnt == DEADCYC-1.
//     DRIVE: digits has one 0 bit at position idx; segments = decode(shadow[4*idx+:4]) with dp.
//            Go to DEAD at cnt == DIV-1.
//   Outputs are registered. The first DRIVE cycle shows the new digit pattern;
//   digits and segments change in the same cycle.
//   load=1: pending <= {dp_in, data_in}. A later load in the same frame overwrites pending (last value wins).
//   Frame boundary (idx 3->0 wrap): shadow <= pending and frame_tick=1 for one cycle.
//   load on the boundary cycle: shadow takes {dp_in, data_in} directly (bypass), and pending gets the same value.
//   Latency: a load is visible no later than the next frame's digit-0 DRIVE phase,
//     i.e. at most 4*DIV + DEADCYC + 1 cycles.
//   Hex decode, active-low, order gfedcba, for 0..F:
//     40 79 24 30 19 12 02 78 00 10 08 03 46 21 06 0E
//   Reset asserted mid-slot: all outputs blank immediately (asynchronous).
//     After release, scanning restarts at idx=0 in DEAD.
//     The first frame_tick comes after 4*DIV cycles; no tick at release.
// CONFIGURATION
//   LEADING_ZERO_BLANK_EN defined:
//     digit k is blanked (segments=8'hFF, digits bit still driven) when all nibbles >= k are 0 and k>0.
//     Digit 0 always shows, so value 0 displays "0".
//     A blanked digit shows its dp if that dp bit is set.
//   LEADING_ZERO_BLANK_EN undefined: all four digits always show, value 0 displays "0000".
// STRUCTURE
//   seg7_pkg: NDIGITS=4; SEG_OFF=8'hFF; 16-entry hex->segment constant table;
//     state encoding localparams DEAD/DRIVE.
//   Sub-module seg7_hexdec: combinational nibble+dp -> 8-bit active-low segments, using the seg7_pkg table.
//   seg7_scan: prescaler, idx counter, FSM, pending/shadow registers, output registers.
// TESTING  (CLKFREQ=100, SCANFREQ=10 -> DIV=10, DEADCYC=2)
//   1. Reset: hold rst=0, then release.
//      -> digits=F, segments=FF for cycles 0-1; cycle 2 digits=E with segments=C0.
//      -> frame_tick first at cycle 40.
//   2. load data_in=16'h1DAD, dp_in=0 mid-frame.
//      -> no change until frame_tick; next frame shows idx0=21, idx1=08, idx2=21, idx3=79.
//   3. Two loads in one frame, 16'h0CED then 16'h1234.
//      -> next frame shows only 1234 (segments 19,30,24,79 for idx0..3); 0CED never appears.
//   4. load 16'hABCD, dp_in=4'b0010, on the frame_tick cycle (bypass).
//      -> the same frame's idx0 DRIVE shows 21; idx1 shows 46 & 7F = 46 (dp bit 7 cleared).
//   5. Assert rst=0 during an idx2 DRIVE phase.
//      -> same cycle digits=F, segments=FF; after release, DEAD on idx0 for 2 cycles.
//   6. LEADING_ZERO_BLANK_EN, value 16'h0007.
//      -> idx0 segments=78, idx1..3 segments=FF; value 0 -> idx0=40.
//      -> Without the macro, value 16'h0007 -> idx1..3 segments=40.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared constants and types for the 4-digit 7-segment scanner.
// Pure declarations, no logic.
// Segment codes are active-low, bit order gfedcba, dp carried separately in bit 7.
package seg7_pkg;

  localparam int NDIGITS = 4;
  localparam logic [7:0] SEG_OFF = 8'hFF;

  // Hex glyphs 0..F, active-low gfedcba; ascending range so entry 0 is listed first.
  localparam logic [0:15][6:0] HEX_SEG = {
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  // Per-slot phase: blanked dead time, then one digit driven.
  typedef enum logic {
    DEAD  = 1'b0,
    DRIVE = 1'b1
  } state_t;

  // Value captured on load: decimal points above the four hex nibbles.
  typedef struct packed {
    logic [3:0]  dp;
    logic [15:0] val;
  } disp_t;

endpackage

// File: rtl/seg7_hexdec.sv
// Nibble + decimal point -> active-low segment byte.
// Combinational, zero latency.
// No flow control; blank forces a-g off while dp still follows its input.
module seg7_hexdec
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       dp,
  input  logic       blank,
  output logic [7:0] seg
);

  // Table lookup for a-g, dp is independent so a blanked digit can still light it.
  always_comb begin
    seg = SEG_OFF;
    if (!blank) begin
      seg[6:0] = HEX_SEG[nibble];
    end
    seg[7] = ~dp;
  end

endmodule

// File: rtl/seg7_scan.sv
// 4-digit multiplexed 7-segment driver with per-slot dead time and frame-aligned updates.
// Outputs registered: a new digit pattern appears on the first DRIVE cycle of its slot.
// load is always accepted; the displayed value only changes at the next digit-0 slot start.
// Optional build macro LEADING_ZERO_BLANK_EN blanks leading zero digits (digit 0 always shown).
module seg7_scan
  import seg7_pkg::*;
#(
  parameter int CLKFREQ  = 27000000,
  parameter int SCANFREQ = 4000,
  parameter int DEADCYC  = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] data_in,
  input  logic        load,
  input  logic [3:0]  dp_in,
  output logic [3:0]  digits,
  output logic [7:0]  segments,
  output logic        frame_tick
);

  localparam int DIV = CLKFREQ / SCANFREQ;
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(DIV - 1);
  localparam logic [CW-1:0] DEAD_LAST = CW'(DEADCYC - 1);

  // The slot must hold at least one dead cycle and leave room for a drive phase.
  if (DIV < DEADCYC + 2 || DEADCYC < 1) begin : g_bad_params
    $error("seg7_scan: DIV must be >= DEADCYC+2 and DEADCYC >= 1");
  end

  logic [CW-1:0] cnt, cnt_nx;
  logic [1:0]    idx, idx_nx;
  logic          wrap;
  state_t        state, state_nx;
  disp_t         pending, shadow, shadow_nx, load_val;
  logic [3:0]    digits_nx;
  logic [7:0]    segments_nx;
  logic [7:0]    dec_seg;
  logic          lz_blank;

  assign load_val = '{dp: dp_in, val: data_in};

  // Slot prescaler and digit index; idx rolls 3->0 naturally in two bits.
  always_comb begin
    wrap   = (cnt == CNT_LAST);
    cnt_nx = cnt + CW'(1);
    idx_nx = idx;
    if (wrap) begin
      cnt_nx = '0;
      idx_nx = idx + 2'd1;
    end
  end

  // Dead-time / drive sequencing within each slot.
  always_comb begin
    state_nx = state;
    case (state)
      DEAD:    if (cnt == DEAD_LAST) state_nx = DRIVE;
      DRIVE:   if (wrap)             state_nx = DEAD;
      default:                       state_nx = DEAD;
    endcase
  end

  // Shadow takes the pending value in the tick cycle; a load in that same cycle bypasses pending.
  always_comb begin
    shadow_nx = shadow;
    if (frame_tick) begin
      shadow_nx = load ? load_val : pending;
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic [15:0] upper;
  // A digit is a leading zero when it and every more-significant nibble are zero.
  always_comb begin
    upper    = shadow_nx.val >> {idx_nx, 2'b00};
    lz_blank = (idx_nx != 2'd0) && (upper == 16'h0000);
  end
`else
  assign lz_blank = 1'b0;
`endif

  seg7_hexdec u_hexdec (
    .nibble (shadow_nx.val[{idx_nx, 2'b00} +: 4]),
    .dp     (shadow_nx.dp[idx_nx]),
    .blank  (lz_blank),
    .seg    (dec_seg)
  );

  // Output pattern for the coming cycle, derived from next-state so outputs switch with the FSM.
  always_comb begin
    digits_nx   = 4'hF;
    segments_nx = SEG_OFF;
    if (state_nx == DRIVE) begin
      digits_nx   = ~(4'b0001 << idx_nx);
      segments_nx = dec_seg;
    end
  end

  // Scan counters and FSM state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt   <= '0;
      idx   <= 2'd0;
      state <= DEAD;
    end else begin
      cnt   <= cnt_nx;
      idx   <= idx_nx;
      state <= state_nx;
    end
  end

  // Pending holds the last load; shadow is what the current frame displays.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending <= '0;
      shadow  <= '0;
    end else begin
      if (load) begin
        pending <= load_val;
      end
      shadow <= shadow_nx;
    end
  end

  // Registered outputs; the tick marks the first cycle of each digit-0 slot.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      digits     <= 4'hF;
      segments   <= SEG_OFF;
      frame_tick <= 1'b0;
    end else begin
      digits     <= digits_nx;
      segments   <= segments_nx;
      frame_tick <= wrap && (idx == 2'd3);
    end
  end

endmodule

// File: tb/tb_seg7_scan.sv
// Self-checking bench for seg7_scan with DIV=10, DEADCYC=2.
// Every cycle is compared against a frame/slot model; a vector table and hand sequences cover corners.
module tb_seg7_scan;

  localparam int DIV   = 10;
  localparam int DEAD  = 2;
  localparam int FRAME = 4 * DIV;
`ifdef LEADING_ZERO_BLANK_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic [15:0] data_in;
  logic        load;
  logic [3:0]  dp_in;
  logic [3:0]  digits;
  logic [7:0]  segments;
  logic        frame_tick;

  seg7_scan #(.CLKFREQ(100), .SCANFREQ(10), .DEADCYC(DEAD)) dut (
    .clk        (clk),
    .rst        (rst),
    .data_in    (data_in),
    .load       (load),
    .dp_in      (dp_in),
    .digits     (digits),
    .segments   (segments),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int t;                    // cycles since reset release
  logic [19:0] pending_m;   // {dp, value} last loaded
  logic [19:0] shown_m;     // {dp, value} displayed this frame

  logic [6:0] hex7 [16];

  typedef struct packed {
    logic [15:0]      data;
    logic [3:0]       dp;
    logic [3:0][7:0]  exp;   // exp[k] = segments for digit k
  } vec_t;
  vec_t vecs [8];

  task automatic check(input string name, input logic [12:0] act, input logic [12:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s t=%0d got=%h expected=%h", name, t, act, exp);
    end
  endtask

  // Expected {digits, segments, frame_tick} for cycle tt from slot arithmetic.
  task automatic model_out(input int tt, output logic [3:0] ed, output logic [7:0] es, output logic et);
    int pos, dig;
    logic [15:0] v;
    logic [3:0]  nib;
    pos = tt % DIV;
    dig = (tt / DIV) % 4;
    et  = (tt > 0) && (tt % FRAME == 0);
    ed  = 4'hF;
    es  = 8'hFF;
    if (pos >= DEAD) begin
      v   = shown_m[15:0];
      nib = 4'((v >> (4 * dig)) & 16'hF);
      ed  = 4'hF & ~(4'(1) << dig);
      es[7] = ~shown_m[16 + dig];
      if (LZB && dig > 0 && (v >> (4 * dig)) == 0) es[6:0] = 7'h7F;
      else es[6:0] = hex7[nib];
    end
  endtask

  // One cycle: compare against the model, then present this cycle's inputs.
  task automatic step(input logic ld, input logic [15:0] d, input logic [3:0] dp);
    logic [3:0] ed; logic [7:0] es; logic et;
    model_out(t, ed, es, et);
    check("cycle", {digits, segments, frame_tick}, {ed, es, et});
    if (et) shown_m = ld ? {dp, d} : pending_m;
    if (ld) pending_m = {dp, d};
    load = ld; data_in = d; dp_in = dp;
    @(negedge clk);
    t++;
  endtask

  task automatic run_to(input int phase);
    step(1'b0, 16'h0, 4'h0);
    while (t % FRAME != phase) step(1'b0, 16'h0, 4'h0);
  endtask

  task automatic release_reset();
    rst = 1'b1;
    t = 0;
    pending_m = '0;
    shown_m = '0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout t=%0d", t);
    $fatal(1, "timeout");
  end

  initial begin
    hex7 = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    vecs[0] = '{16'h1DAD, 4'b0000, {8'hF9, 8'hA1, 8'h88, 8'hA1}};
    vecs[1] = '{16'h1234, 4'b0000, {8'hF9, 8'hA4, 8'hB0, 8'h99}};
    vecs[2] = '{16'hABCD, 4'b0010, {8'h88, 8'h83, 8'h46, 8'hA1}};
    vecs[3] = '{16'h0007, 4'b0000, {LZB ? 8'hFF : 8'hC0, LZB ? 8'hFF : 8'hC0, LZB ? 8'hFF : 8'hC0, 8'hF8}};
    vecs[4] = '{16'h0000, 4'b0000, {LZB ? 8'hFF : 8'hC0, LZB ? 8'hFF : 8'hC0, LZB ? 8'hFF : 8'hC0, 8'hC0}};
    vecs[5] = '{16'h0000, 4'b1000, {LZB ? 8'h7F : 8'h40, LZB ? 8'hFF : 8'hC0, LZB ? 8'hFF : 8'hC0, 8'hC0}};
    vecs[6] = '{16'h89EF, 4'b1111, {8'h00, 8'h10, 8'h06, 8'h0E}};
    vecs[7] = '{16'h0500, 4'b0000, {LZB ? 8'hFF : 8'hC0, 8'h92, 8'hC0, 8'hC0}};

    clk = 1'b0; rst = 1'b0; load = 1'b0; data_in = '0; dp_in = '0; t = 0;
    pending_m = '0; shown_m = '0;

    // Reset state while held.
    repeat (3) @(negedge clk);
    check("reset_hold", {digits, segments, frame_tick}, {4'hF, 8'hFF, 1'b0});
    release_reset();

    // Cycles 0-1 dead, cycle 2 shows digit 0 of value 0; first tick at 40 via the model.
    step(1'b0, 16'h0, 4'h0);
    step(1'b0, 16'h0, 4'h0);
    check("first_drive", {digits, segments, frame_tick}, {4'hE, 8'hC0, 1'b0});
    run_to(0);
    check("first_tick_t", 13'(t), 13'(FRAME));

    // Table: load mid-frame, expect the glyphs in the following frame.
    for (int i = 0; i < 8; i++) begin
      run_to(15);
      step(1'b1, vecs[i].data, vecs[i].dp);
      run_to(0);
      for (int k = 0; k < 4; k++) begin
        run_to(k * DIV + DEAD);
        check("vec_seg", {5'h0, segments}, {5'h0, vecs[i].exp[k]});
      end
    end

    // Two loads in one frame: last wins.
    run_to(10);
    step(1'b1, 16'h0CED, 4'h0);
    run_to(25);
    step(1'b1, 16'h1234, 4'h0);
    run_to(0);
    for (int k = 0; k < 4; k++) begin
      run_to(k * DIV + DEAD);
      check("last_wins", {5'h0, segments}, {5'h0, vecs[1].exp[k]});
    end

    // Bypass: a load on the tick cycle beats an earlier pending value.
    run_to(20);
    step(1'b1, 16'h1111, 4'h0);
    run_to(0);
    step(1'b1, 16'hABCD, 4'b0010);
    for (int k = 0; k < 4; k++) begin
      run_to(k * DIV + DEAD);
      check("bypass", {5'h0, segments}, {5'h0, vecs[2].exp[k]});
    end

    // Asynchronous reset during an idx2 drive phase.
    run_to(2 * DIV + 5);
    check("pre_reset_idx2", {9'h0, digits}, {9'h0, 4'hB});
    #1 rst = 1'b0;
    #1 check("async_blank", {digits, segments, frame_tick}, {4'hF, 8'hFF, 1'b0});
    repeat (2) @(negedge clk);
    check("reset_hold2", {digits, segments, frame_tick}, {4'hF, 8'hFF, 1'b0});
    release_reset();
    for (int i = 0; i < 2 * FRAME + 5; i++) step(1'b0, 16'h0, 4'h0);

    // Random loads checked cycle by cycle against the model.
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 9) == 0)
        step(1'b1, 16'($urandom), 4'($urandom));
      else
        step(1'b0, 16'h0, 4'h0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
